// File: rtl/mips_datapath_idex_stage_if.sv
// Clock/reset bundle shared by the datapath stages; reset is synchronous and active-high.
interface mips_datapath_idex_stage_if;
  logic clock;
  logic reset;

  modport sink (input clock, input reset);
endinterface

// File: rtl/mips_datapath_idex_stage.sv
// ID/EX pipeline register: load-use bubble insertion, same-cycle writeback bypass,
// downstream hold with operand refresh, and a saturating bubble counter.
module mips_datapath_idex_stage #(
  parameter int CTRL_W = 64,
  parameter int CNT_W  = 16
) (
  mips_datapath_idex_stage_if.sink ctrl,
  input  logic              id_valid,
  input  logic              id_squash,
  input  logic [CTRL_W-1:0] id_control,
  input  logic [31:0]       id_instruction,
  input  logic [31:0]       id_pcAddr,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [31:0]       id_port1,
  input  logic [31:0]       id_port2,
  input  logic [4:0]        id_wrAddr,
  input  logic              id_wrEn,
  input  logic              id_isLoad,
  input  logic              wb_wrEn,
  input  logic [4:0]        wb_wrAddr,
  input  logic [31:0]       wb_wrData,
  input  logic              ex_hold,
  output logic              stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_control,
  output logic [31:0]       ex_instruction,
  output logic [31:0]       ex_pcAddr,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [31:0]       ex_op1,
  output logic [31:0]       ex_op2,
  output logic [4:0]        ex_wrAddr,
  output logic              ex_wrEn,
  output logic              ex_isLoad,
  output logic [CNT_W-1:0]  bubbleCount
);

  logic              ex_valid_q,       ex_valid_d;
  logic [CTRL_W-1:0] ex_control_q,     ex_control_d;
  logic [31:0]       ex_instruction_q, ex_instruction_d;
  logic [31:0]       ex_pcAddr_q,      ex_pcAddr_d;
  logic [4:0]        ex_rs_q,          ex_rs_d;
  logic [4:0]        ex_rt_q,          ex_rt_d;
  logic [31:0]       ex_op1_q,         ex_op1_d;
  logic [31:0]       ex_op2_q,         ex_op2_d;
  logic [4:0]        ex_wrAddr_q,      ex_wrAddr_d;
  logic              ex_wrEn_q,        ex_wrEn_d;
  logic              ex_isLoad_q,      ex_isLoad_d;
  logic [CNT_W-1:0]  bubbleCount_q,    bubbleCount_d;

  logic        live;
  logic        lu;
  logic        wb_live;
  logic [31:0] op1_byp;
  logic [31:0] op2_byp;

  always_comb begin
    live    = id_valid & ~id_squash;
    lu      = live & ex_valid_q & ex_isLoad_q & ex_wrEn_q & (ex_wrAddr_q != 5'd0)
              & ((ex_wrAddr_q == id_rs) | (ex_wrAddr_q == id_rt));
    stall   = ctrl.reset ? 1'b0 : (ex_hold | lu);

    // Register file does not pass through same-cycle writes, so forward them here.
    wb_live = wb_wrEn & (wb_wrAddr != 5'd0);
    op1_byp = (wb_live & (wb_wrAddr == id_rs)) ? wb_wrData : id_port1;
    op2_byp = (wb_live & (wb_wrAddr == id_rt)) ? wb_wrData : id_port2;
  end

  always_comb begin
    ex_valid_d       = ex_valid_q;
    ex_control_d     = ex_control_q;
    ex_instruction_d = ex_instruction_q;
    ex_pcAddr_d      = ex_pcAddr_q;
    ex_rs_d          = ex_rs_q;
    ex_rt_d          = ex_rt_q;
    ex_op1_d         = ex_op1_q;
    ex_op2_d         = ex_op2_q;
    ex_wrAddr_d      = ex_wrAddr_q;
    ex_wrEn_d        = ex_wrEn_q;
    ex_isLoad_d      = ex_isLoad_q;
    bubbleCount_d    = bubbleCount_q;

    if (ex_hold) begin
      // Frozen instruction still picks up results retiring while it waits.
      if (wb_live && (wb_wrAddr == ex_rs_q)) ex_op1_d = wb_wrData;
      if (wb_live && (wb_wrAddr == ex_rt_q)) ex_op2_d = wb_wrData;
    end else if (lu || !live) begin
      ex_valid_d   = 1'b0;
      ex_control_d = '0;
      ex_wrEn_d    = 1'b0;
      ex_isLoad_d  = 1'b0;
      if (lu && (bubbleCount_q != {CNT_W{1'b1}})) begin
        bubbleCount_d = bubbleCount_q + CNT_W'(1);
      end
    end else begin
      ex_valid_d       = 1'b1;
      ex_control_d     = id_control;
      ex_instruction_d = id_instruction;
      ex_pcAddr_d      = id_pcAddr;
      ex_rs_d          = id_rs;
      ex_rt_d          = id_rt;
      ex_op1_d         = op1_byp;
      ex_op2_d         = op2_byp;
      ex_wrAddr_d      = id_wrAddr;
      ex_wrEn_d        = id_wrEn;
      ex_isLoad_d      = id_isLoad;
    end
  end

  always_ff @(posedge ctrl.clock) begin
    if (ctrl.reset) begin
      ex_valid_q       <= 1'b0;
      ex_control_q     <= '0;
      ex_instruction_q <= '0;
      ex_pcAddr_q      <= '0;
      ex_rs_q          <= '0;
      ex_rt_q          <= '0;
      ex_op1_q         <= '0;
      ex_op2_q         <= '0;
      ex_wrAddr_q      <= '0;
      ex_wrEn_q        <= 1'b0;
      ex_isLoad_q      <= 1'b0;
      bubbleCount_q    <= '0;
    end else begin
      ex_valid_q       <= ex_valid_d;
      ex_control_q     <= ex_control_d;
      ex_instruction_q <= ex_instruction_d;
      ex_pcAddr_q      <= ex_pcAddr_d;
      ex_rs_q          <= ex_rs_d;
      ex_rt_q          <= ex_rt_d;
      ex_op1_q         <= ex_op1_d;
      ex_op2_q         <= ex_op2_d;
      ex_wrAddr_q      <= ex_wrAddr_d;
      ex_wrEn_q        <= ex_wrEn_d;
      ex_isLoad_q      <= ex_isLoad_d;
      bubbleCount_q    <= bubbleCount_d;
    end
  end

  assign ex_valid       = ex_valid_q;
  assign ex_control     = ex_control_q;
  assign ex_instruction = ex_instruction_q;
  assign ex_pcAddr      = ex_pcAddr_q;
  assign ex_rs          = ex_rs_q;
  assign ex_rt          = ex_rt_q;
  assign ex_op1         = ex_op1_q;
  assign ex_op2         = ex_op2_q;
  assign ex_wrAddr      = ex_wrAddr_q;
  assign ex_wrEn        = ex_wrEn_q;
  assign ex_isLoad      = ex_isLoad_q;
  assign bubbleCount    = bubbleCount_q;

endmodule

// File: tb/tb_mips_datapath_idex_stage.sv
// Directed bench for the ID/EX stage: a vector table for single-cycle behaviour plus
// hand sequences for hold, reset-during-hold and bubble-counter saturation.
module tb_mips_datapath_idex_stage;
  localparam int CTRL_W = 64;
  localparam int CNT_W  = 4;

  mips_datapath_idex_stage_if ctrl_if ();

  logic              id_valid, id_squash;
  logic [CTRL_W-1:0] id_control;
  logic [31:0]       id_instruction, id_pcAddr, id_port1, id_port2;
  logic [4:0]        id_rs, id_rt, id_wrAddr;
  logic              id_wrEn, id_isLoad;
  logic              wb_wrEn;
  logic [4:0]        wb_wrAddr;
  logic [31:0]       wb_wrData;
  logic              ex_hold;
  logic              stall, ex_valid, ex_wrEn, ex_isLoad;
  logic [CTRL_W-1:0] ex_control;
  logic [31:0]       ex_instruction, ex_pcAddr, ex_op1, ex_op2;
  logic [4:0]        ex_rs, ex_rt, ex_wrAddr;
  logic [CNT_W-1:0]  bubbleCount;

  int n_vec = 0;
  int n_bad = 0;

  mips_datapath_idex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .ctrl(ctrl_if), .id_valid(id_valid), .id_squash(id_squash), .id_control(id_control),
    .id_instruction(id_instruction), .id_pcAddr(id_pcAddr), .id_rs(id_rs), .id_rt(id_rt),
    .id_port1(id_port1), .id_port2(id_port2), .id_wrAddr(id_wrAddr), .id_wrEn(id_wrEn),
    .id_isLoad(id_isLoad), .wb_wrEn(wb_wrEn), .wb_wrAddr(wb_wrAddr), .wb_wrData(wb_wrData),
    .ex_hold(ex_hold), .stall(stall), .ex_valid(ex_valid), .ex_control(ex_control),
    .ex_instruction(ex_instruction), .ex_pcAddr(ex_pcAddr), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_wrAddr(ex_wrAddr), .ex_wrEn(ex_wrEn),
    .ex_isLoad(ex_isLoad), .bubbleCount(bubbleCount)
  );

  initial ctrl_if.clock = 1'b0;
  always #5 ctrl_if.clock = ~ctrl_if.clock;

  typedef struct {
    logic        v, sq;
    logic [63:0] c;
    logic [4:0]  rs, rt;
    logic [31:0] p1, p2;
    logic [4:0]  wa;
    logic        we, ld, wbe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        e_stall, cap;
    logic [31:0] e_op1, e_op2;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic v, logic sq, logic [63:0] c, logic [4:0] rs, logic [4:0] rt,
                              logic [31:0] p1, logic [31:0] p2, logic [4:0] wa, logic we,
                              logic ld, logic wbe, logic [4:0] wba, logic [31:0] wbd,
                              logic es, logic cap, logic [31:0] eo1, logic [31:0] eo2,
                              logic [3:0] ecnt);
    vec_t r;
    r.v = v; r.sq = sq; r.c = c; r.rs = rs; r.rt = rt; r.p1 = p1; r.p2 = p2;
    r.wa = wa; r.we = we; r.ld = ld; r.wbe = wbe; r.wba = wba; r.wbd = wbd;
    r.e_stall = es; r.cap = cap; r.e_op1 = eo1; r.e_op2 = eo2; r.e_cnt = ecnt;
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic sq, input logic [63:0] c, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [31:0] p1, input logic [31:0] p2,
                        input logic [4:0] wa, input logic we, input logic ld,
                        input logic [31:0] instr, input logic [31:0] pc);
    id_valid = v; id_squash = sq; id_control = c; id_rs = rs; id_rt = rt;
    id_port1 = p1; id_port2 = p2; id_wrAddr = wa; id_wrEn = we; id_isLoad = ld;
    id_instruction = instr; id_pcAddr = pc;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    wb_wrEn = en; wb_wrAddr = a; wb_wrData = d;
  endtask

  task automatic tick();
    @(posedge ctrl_if.clock);
    #1;
  endtask

  initial begin
    // Vector table: each entry is applied for one cycle; state carries from entry to entry.
    vecs[0]  = mk(1,0,64'hA5, 5, 6, 32'h11,  32'h22, 9, 1,0, 1, 5,32'hABCD, 0,1, 32'hABCD,32'h22, 0);
    vecs[1]  = mk(1,0,64'h01, 5, 0, 32'h11,  32'h33, 9, 1,0, 1, 0,32'hFFFF, 0,1, 32'h11,  32'h33, 0);
    vecs[2]  = mk(1,0,64'h02,29, 8, 32'h1000,32'h0,  8, 1,1, 0, 0,32'h0,    0,1, 32'h1000,32'h0,  0);
    vecs[3]  = mk(1,0,64'h03, 8, 4, 32'h77,  32'h44, 9, 1,0, 0, 0,32'h0,    1,0, 32'h0,   32'h0,  1);
    vecs[4]  = mk(1,0,64'h03, 8, 4, 32'h77,  32'h44, 9, 1,0, 0, 0,32'h0,    0,1, 32'h77,  32'h44, 1);
    vecs[5]  = mk(1,0,64'h04, 1, 0, 32'h10,  32'h0,  0, 1,1, 0, 0,32'h0,    0,1, 32'h10,  32'h0,  1);
    vecs[6]  = mk(1,0,64'h05, 0, 0, 32'h0,   32'h0,  3, 1,0, 1, 0,32'hDEAD, 0,1, 32'h0,   32'h0,  1);
    vecs[7]  = mk(1,0,64'h06, 2,10, 32'h200, 32'h5, 10, 1,1, 0, 0,32'h0,    0,1, 32'h200, 32'h5,  1);
    vecs[8]  = mk(1,1,64'h07,10, 9, 32'h0,   32'h0,  9, 1,1, 0, 0,32'h0,    0,0, 32'h0,   32'h0,  1);
    vecs[9]  = mk(0,0,64'h08,10,10, 32'h0,   32'h0,  0, 0,0, 0, 0,32'h0,    0,0, 32'h0,   32'h0,  1);
    vecs[10] = mk(1,0,64'h09, 3,12, 32'h300, 32'h0, 12, 1,1, 0, 0,32'h0,    0,1, 32'h300, 32'h0,  1);
    vecs[11] = mk(1,0,64'h0A, 1,12, 32'h1,   32'h99,13, 1,0, 1,12,32'h1234, 1,0, 32'h0,   32'h0,  2);
    vecs[12] = mk(1,0,64'h0A, 1,12, 32'h1,   32'h99,13, 1,0, 1,12,32'h1234, 0,1, 32'h1,   32'h1234,2);

    // Reset for one cycle.
    ctrl_if.reset = 1'b1;
    ex_hold = 1'b0;
    set_id(0,0,64'h0,0,0,32'h0,32'h0,0,0,0,32'h0,32'h0);
    set_wb(0,0,32'h0);
    #1;
    check("reset_stall", 64'(stall), 64'h0);
    tick();
    check("reset_ex_valid",   64'(ex_valid),    64'h0);
    check("reset_ex_control", ex_control,       64'h0);
    check("reset_bubbles",    64'(bubbleCount), 64'h0);
    ctrl_if.reset = 1'b0;
    $display("reset: ex_valid=%0b bubbles=%0d", ex_valid, bubbleCount);

    for (int i = 0; i < 13; i++) begin
      logic [31:0] instr, pc;
      instr = 32'hC0DE_0000 | 32'(i);
      pc    = 32'h0040_0000 + 32'(4 * i);
      set_id(vecs[i].v, vecs[i].sq, vecs[i].c, vecs[i].rs, vecs[i].rt, vecs[i].p1, vecs[i].p2,
             vecs[i].wa, vecs[i].we, vecs[i].ld, instr, pc);
      set_wb(vecs[i].wbe, vecs[i].wba, vecs[i].wbd);
      ex_hold = 1'b0;
      #1;
      check($sformatf("v%0d_stall", i), 64'(stall), 64'(vecs[i].e_stall));
      tick();
      check($sformatf("v%0d_ex_valid", i),  64'(ex_valid),  64'(vecs[i].cap));
      check($sformatf("v%0d_ex_control", i), ex_control,    vecs[i].cap ? vecs[i].c : 64'h0);
      check($sformatf("v%0d_ex_wrEn", i),   64'(ex_wrEn),   64'(vecs[i].cap & vecs[i].we));
      check($sformatf("v%0d_ex_isLoad", i), 64'(ex_isLoad), 64'(vecs[i].cap & vecs[i].ld));
      check($sformatf("v%0d_bubbles", i),   64'(bubbleCount), 64'(vecs[i].e_cnt));
      if (vecs[i].cap) begin
        check($sformatf("v%0d_ex_op1", i),   64'(ex_op1),    64'(vecs[i].e_op1));
        check($sformatf("v%0d_ex_op2", i),   64'(ex_op2),    64'(vecs[i].e_op2));
        check($sformatf("v%0d_ex_rs", i),    64'(ex_rs),     64'(vecs[i].rs));
        check($sformatf("v%0d_ex_rt", i),    64'(ex_rt),     64'(vecs[i].rt));
        check($sformatf("v%0d_ex_wrAddr", i),64'(ex_wrAddr), 64'(vecs[i].wa));
        check($sformatf("v%0d_ex_instr", i), 64'(ex_instruction), 64'(instr));
        check($sformatf("v%0d_ex_pc", i),    64'(ex_pcAddr), 64'(pc));
      end
      $display("vec %0d: stall=%0b ex_valid=%0b op1=%h op2=%h bubbles=%0d",
               i, stall, ex_valid, ex_op1, ex_op2, bubbleCount);
    end

    // Hold: capture an instruction with rt=7, then freeze for three cycles.
    set_id(1,0,64'h8,3,7,32'h31,32'h71,11,1,0,32'hAAAA_0001,32'h0000_1004);
    set_wb(0,0,32'h0);
    ex_hold = 1'b0;
    #1;
    check("hold_pre_stall", 64'(stall), 64'h0);
    tick();
    check("hold_pre_op2", 64'(ex_op2), 64'h71);
    for (int c = 0; c < 3; c++) begin
      logic [31:0] want_op2;
      ex_hold = 1'b1;
      set_id(1,1,64'hFF,7,7,32'hEEEE,32'hEEEE,7,1,1,32'hBAD0_BAD0,32'hBAD0_0000);
      if (c == 0)      set_wb(1,9,32'h99);
      else if (c == 1) set_wb(1,7,32'h55);
      else             set_wb(0,0,32'h0);
      want_op2 = (c == 0) ? 32'h71 : 32'h55;
      #1;
      check($sformatf("hold%0d_stall", c), 64'(stall), 64'h1);
      tick();
      check($sformatf("hold%0d_ex_valid", c),  64'(ex_valid),  64'h1);
      check($sformatf("hold%0d_ex_control", c), ex_control,    64'h8);
      check($sformatf("hold%0d_ex_instr", c),  64'(ex_instruction), 64'hAAAA_0001);
      check($sformatf("hold%0d_ex_pc", c),     64'(ex_pcAddr), 64'h0000_1004);
      check($sformatf("hold%0d_ex_rs", c),     64'(ex_rs),     64'd3);
      check($sformatf("hold%0d_ex_rt", c),     64'(ex_rt),     64'd7);
      check($sformatf("hold%0d_ex_wrAddr", c), 64'(ex_wrAddr), 64'd11);
      check($sformatf("hold%0d_ex_isLoad", c), 64'(ex_isLoad), 64'h0);
      check($sformatf("hold%0d_ex_op1", c),    64'(ex_op1),    64'h31);
      check($sformatf("hold%0d_ex_op2", c),    64'(ex_op2),    64'(want_op2));
      check($sformatf("hold%0d_bubbles", c),   64'(bubbleCount), 64'd2);
      $display("hold %0d: stall=%0b op1=%h op2=%h", c, stall, ex_op1, ex_op2);
    end

    // Reset arriving while the stage is held.
    ctrl_if.reset = 1'b1;
    #1;
    check("rsthold_stall", 64'(stall), 64'h0);
    tick();
    check("rsthold_ex_valid", 64'(ex_valid),    64'h0);
    check("rsthold_control",  ex_control,       64'h0);
    check("rsthold_op2",      64'(ex_op2),      64'h0);
    check("rsthold_wrEn",     64'(ex_wrEn),     64'h0);
    check("rsthold_bubbles",  64'(bubbleCount), 64'h0);
    ctrl_if.reset = 1'b0;
    ex_hold = 1'b0;
    set_id(0,0,64'h0,0,0,32'h0,32'h0,0,0,0,32'h0,32'h0);
    set_wb(0,0,32'h0);
    #1;
    check("rsthold_post_stall", 64'(stall), 64'h0);
    tick();
    check("rsthold_post_valid", 64'(ex_valid), 64'h0);
    $display("reset during hold: stall=%0b ex_valid=%0b bubbles=%0d", stall, ex_valid, bubbleCount);

    // Bubble counter saturation: 17 load-use pairs into a 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      set_id(1,0,64'h1,1,8,32'h4,32'h0,8,1,1,32'h8C28_0000,32'h0000_2000);
      #1;
      tick();
      set_id(1,0,64'h2,8,4,32'h0,32'h0,9,1,0,32'h0104_4820,32'h0000_2004);
      #1;
      check($sformatf("sat%0d_stall", i), 64'(stall), 64'h1);
      tick();
      check($sformatf("sat%0d_bubbles", i), 64'(bubbleCount), 64'((i < 15) ? i + 1 : 15));
      $display("sat %0d: bubbles=%0d", i, bubbleCount);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
